// File: rtl/branch_resolver.sv
// Branch resolution arbiter: emits the oldest mispredict at once, and queues
// correctly predicted branches in a small FIFO that drains on idle cycles.
module branch_resolver_lane #(
  parameter int W = 4
) (
  input  logic         i_flush,
  input  logic         i_valid,
  input  logic         i_mispredict,
  input  logic [W-1:0] i_rob_id,
  input  logic [W-1:0] i_rob_head,
  output logic         o_is_m,
  output logic         o_is_c,
  output logic [W-1:0] o_age
);
  // Modular subtraction gives the ROB age directly, wrap included.
  assign o_age  = i_rob_id - i_rob_head;
  assign o_is_m = i_valid & i_mispredict & ~i_flush;
  assign o_is_c = i_valid & ~i_mispredict & ~i_flush;
endmodule

module branch_resolver #(
  parameter int N_BRU          = 2,
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int TRAIN_DEPTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [ROB_ADDR_WIDTH-1:0]            rob_head,
  input  logic [N_BRU-1:0]                     bru_valid,
  input  logic [N_BRU-1:0]                     bru_mispredict,
  input  logic [N_BRU-1:0]                     bru_taken,
  input  logic [N_BRU*ROB_ADDR_WIDTH-1:0]      bru_rob_id,
  input  logic [N_BRU*32-1:0]                  bru_pc,
  input  logic [N_BRU*32-1:0]                  bru_target,
  output logic                                 resolved_valid,
  output logic                                 resolved_mispredict,
  output logic                                 resolved_taken,
  output logic [ROB_ADDR_WIDTH-1:0]            resolved_rob_id,
  output logic [31:0]                          resolved_pc,
  output logic [31:0]                          resolved_target,
  output logic [$clog2(TRAIN_DEPTH+1)-1:0]     train_cnt,
  output logic [15:0]                          train_drop_cnt
);
  localparam int W  = ROB_ADDR_WIDTH;
  localparam int PW = $clog2(TRAIN_DEPTH);
  localparam int CW = $clog2(TRAIN_DEPTH+1);
  localparam int DW = $clog2(N_BRU+1);

  typedef struct packed {
    logic         taken;
    logic [W-1:0] rob_id;
    logic [31:0]  pc;
    logic [31:0]  target;
  } ent_t;

  ent_t                    w_ent [N_BRU];
  logic [N_BRU-1:0]        w_is_m, w_is_c;
  logic [N_BRU-1:0][W-1:0] w_age;

  for (genvar g = 0; g < N_BRU; g++) begin : g_lane
    branch_resolver_lane #(.W(W)) u_lane (
      .i_flush      (flush),
      .i_valid      (bru_valid[g]),
      .i_mispredict (bru_mispredict[g]),
      .i_rob_id     (bru_rob_id[g*W +: W]),
      .i_rob_head   (rob_head),
      .o_is_m       (w_is_m[g]),
      .o_is_c       (w_is_c[g]),
      .o_age        (w_age[g])
    );
    assign w_ent[g] = '{taken: bru_taken[g], rob_id: bru_rob_id[g*W +: W],
                        pc: bru_pc[g*32 +: 32], target: bru_target[g*32 +: 32]};
  end

  ent_t            r_mem [TRAIN_DEPTH];
  logic [PW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]   r_cnt;
  logic [15:0]     r_drop;
  logic            r_valid, r_mispredict;
  ent_t            r_out;

  // Oldest mispredict; strict '<' keeps the lower unit on age ties.
  logic            w_sel_vld;
  logic [W-1:0]    w_sel_age;
  ent_t            w_sel;
  always_comb begin
    w_sel_vld = 1'b0;
    w_sel_age = '0;
    w_sel     = '0;
    for (int i = 0; i < N_BRU; i++) begin
      if (w_is_m[i] && (!w_sel_vld || w_age[i] < w_sel_age)) begin
        w_sel_vld = 1'b1;
        w_sel_age = w_age[i];
        w_sel     = w_ent[i];
      end
    end
  end

  // Free slots come from the pre-pop count, so a popped slot is not reused this cycle.
  logic [CW-1:0]            w_free, w_npush;
  logic [DW-1:0]            w_ndrop;
  logic [N_BRU-1:0]         w_acc;
  logic [N_BRU-1:0][PW-1:0] w_slot;
  always_comb begin
    w_free  = CW'(TRAIN_DEPTH) - r_cnt;
    w_npush = '0;
    w_ndrop = '0;
    w_acc   = '0;
    w_slot  = '0;
    for (int i = 0; i < N_BRU; i++) begin
      if (w_is_c[i]) begin
        if (w_npush < w_free) begin
          w_acc[i]  = 1'b1;
          w_slot[i] = r_wr_ptr + w_npush[PW-1:0];
          w_npush   = w_npush + CW'(1);
        end else begin
          w_ndrop   = w_ndrop + DW'(1);
        end
      end
    end
  end

  logic        w_pop;
  logic [16:0] w_drop_sum;
  ent_t        w_head;
  assign w_pop      = ~flush & ~w_sel_vld & (r_cnt != '0);
  assign w_drop_sum = {1'b0, r_drop} + 17'(w_ndrop);
  assign w_head     = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      for (int i = 0; i < N_BRU; i++)
        if (w_acc[i]) r_mem[w_slot[i]] <= w_ent[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_cnt        <= '0;
      r_drop       <= '0;
      r_valid      <= 1'b0;
      r_mispredict <= 1'b0;
      r_out        <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + w_npush[PW-1:0];
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_cnt    <= r_cnt + w_npush - CW'(w_pop);
      r_drop   <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
      r_valid  <= w_sel_vld | w_pop;
      if (w_sel_vld) begin
        r_mispredict <= 1'b1;
        r_out        <= w_sel;
      end else if (w_pop) begin
        r_mispredict <= 1'b0;
        r_out        <= w_head;
      end
    end
  end

  assign resolved_valid      = r_valid;
  assign resolved_mispredict = r_mispredict;
  assign resolved_taken      = r_out.taken;
  assign resolved_rob_id     = r_out.rob_id;
  assign resolved_pc         = r_out.pc;
  assign resolved_target     = r_out.target;
  assign train_cnt           = r_cnt;
  assign train_drop_cnt      = r_drop;
endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver against a queue-based reference model.
module tb_branch_resolver;
  localparam int N = 2, W = 4, D = 4;

  logic            clk = 1'b0;
  logic            rst, flush;
  logic [W-1:0]    rob_head;
  logic [N-1:0]    bru_valid, bru_mispredict, bru_taken;
  logic [N*W-1:0]  bru_rob_id;
  logic [N*32-1:0] bru_pc, bru_target;
  logic            resolved_valid, resolved_mispredict, resolved_taken;
  logic [W-1:0]    resolved_rob_id;
  logic [31:0]     resolved_pc, resolved_target;
  logic [2:0]      train_cnt;
  logic [15:0]     train_drop_cnt;

  branch_resolver #(.N_BRU(N), .ROB_ADDR_WIDTH(W), .TRAIN_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .bru_valid(bru_valid), .bru_mispredict(bru_mispredict), .bru_taken(bru_taken),
    .bru_rob_id(bru_rob_id), .bru_pc(bru_pc), .bru_target(bru_target),
    .resolved_valid(resolved_valid), .resolved_mispredict(resolved_mispredict),
    .resolved_taken(resolved_taken), .resolved_rob_id(resolved_rob_id),
    .resolved_pc(resolved_pc), .resolved_target(resolved_target),
    .train_cnt(train_cnt), .train_drop_cnt(train_drop_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic        m, t;
    logic [3:0]  id;
    logic [31:0] pc, tgt;
    int          cyc;
  } ent_t;

  ent_t sb[$];   // expected outputs
  ent_t mq[$];   // model training FIFO
  int   m_drop = 0, exp_cnt = 0, exp_drop = 0;
  int   total = 0, bad = 0, cyc = 0;
  bit   chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: applies this cycle's inputs as the coming clock edge would.
  task automatic model();
    int best, best_age, a, pre, acc;
    ent_t e;
    if (rst) begin
      mq.delete();
      m_drop = 0;
    end else if (flush) begin
      mq.delete();
    end else begin
      best = -1; best_age = 0;
      for (int i = 0; i < N; i++) begin
        if (bru_valid[i] && bru_mispredict[i]) begin
          a = ((int'(bru_rob_id[i*W +: W]) - int'(rob_head)) % 16 + 16) % 16;
          if (best < 0 || a < best_age) begin best = i; best_age = a; end
        end
      end
      pre = mq.size();
      if (best >= 0) begin
        e.m = 1; e.t = bru_taken[best]; e.id = bru_rob_id[best*W +: W];
        e.pc = bru_pc[best*32 +: 32]; e.tgt = bru_target[best*32 +: 32];
        e.cyc = cyc + 1;
        sb.push_back(e);
      end else if (pre > 0) begin
        e = mq.pop_front();
        e.m = 0; e.cyc = cyc + 1;
        sb.push_back(e);
      end
      acc = 0;
      for (int i = 0; i < N; i++) begin
        if (bru_valid[i] && !bru_mispredict[i]) begin
          if (acc < D - pre) begin
            e.m = 0; e.t = bru_taken[i]; e.id = bru_rob_id[i*W +: W];
            e.pc = bru_pc[i*32 +: 32]; e.tgt = bru_target[i*32 +: 32]; e.cyc = 0;
            mq.push_back(e);
            acc++;
          end else if (m_drop < 65535) m_drop++;
        end
      end
    end
    exp_cnt  = mq.size();
    exp_drop = m_drop;
  endtask

  always @(posedge clk) begin
    ent_t e;
    #1;
    if (chk_en) begin
      chk("train_cnt", 128'(train_cnt), 128'(exp_cnt));
      chk("train_drop_cnt", 128'(train_drop_cnt), 128'(exp_drop));
      if (resolved_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_valid", 128'(1), 128'(0));
        end else begin
          e = sb.pop_front();
          chk("result", {resolved_mispredict, resolved_taken, resolved_rob_id, resolved_pc, resolved_target},
                        {e.m, e.t, e.id, e.pc, e.tgt});
          chk("latency", 128'(cyc), 128'(e.cyc));
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        chk("missing_valid", 128'(0), 128'(1));
        void'(sb.pop_front());
      end
    end
  end

  task automatic idle_inputs();
    rst = 0; flush = 0; bru_valid = '0; bru_mispredict = '0; bru_taken = '0;
    bru_rob_id = '0; bru_pc = '0; bru_target = '0;
  endtask

  task automatic set_unit(input int i, input logic m, input logic t, input logic [3:0] id,
                          input logic [31:0] pc, input logic [31:0] tgt);
    bru_valid[i] = 1'b1; bru_mispredict[i] = m; bru_taken[i] = t;
    bru_rob_id[i*W +: W] = id; bru_pc[i*32 +: 32] = pc; bru_target[i*32 +: 32] = tgt;
  endtask

  task automatic step();
    model();
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic check_all_zero(input string name);
    @(posedge clk); #2;
    chk(name, {resolved_valid, resolved_mispredict, resolved_taken, resolved_rob_id,
               resolved_pc, resolved_target, train_cnt, train_drop_cnt}, '0);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rob_head = '0;
    @(negedge clk);
    rst = 1;
    chk_en = 1;
    model();
    check_all_zero("reset_state");
    idle_inputs();

    // single mispredict
    set_unit(0, 1, 1, 4'd3, 32'h8000_0000, 32'h8000_0100);
    step(); step(); step();

    // age compare across wrap
    rob_head = 4'd14;
    set_unit(0, 1, 0, 4'd1, 32'h100, 32'h200);
    set_unit(1, 1, 1, 4'd15, 32'h300, 32'h400);
    step(); step();
    // equal age: lower unit wins
    set_unit(0, 1, 0, 4'd5, 32'h111, 32'h222);
    set_unit(1, 1, 1, 4'd5, 32'h333, 32'h444);
    step(); step();

    // training drain and overflow
    rob_head = 4'd0;
    for (int c = 0; c < 3; c++) begin
      set_unit(0, 0, 1, 4'(2*c),   32'h1000 + 32'(c), 32'h2000 + 32'(c));
      set_unit(1, 0, 0, 4'(2*c+1), 32'h3000 + 32'(c), 32'h4000 + 32'(c));
      step();
    end
    step();
    // mispredict preempts training (FIFO holds 2 here)
    set_unit(1, 1, 1, 4'd9, 32'h5000, 32'h6000);
    step();
    for (int c = 0; c < 4; c++) step();

    // flush clears state: build 3 entries, then flush with a mispredict
    for (int c = 0; c < 3; c++) begin
      set_unit(0, 1, 0, 4'(c), 32'h7000 + 32'(c), 32'h7100 + 32'(c));
      set_unit(1, 0, 1, 4'(c + 8), 32'h7200 + 32'(c), 32'h7300 + 32'(c));
      step();
    end
    flush = 1;
    set_unit(0, 1, 1, 4'd2, 32'h7777, 32'h8888);
    step(); step();

    // reset mid-stream with FIFO full and output valid
    for (int c = 0; c < 6; c++) begin
      set_unit(0, 1, 0, 4'(c), 32'h9000 + 32'(c), 32'h9100 + 32'(c));
      set_unit(1, 0, 1, 4'(c + 8), 32'h9200 + 32'(c), 32'h9300 + 32'(c));
      step();
    end
    rst = 1;
    set_unit(0, 1, 0, 4'd1, 32'h1, 32'h2);
    model();
    check_all_zero("reset_midstream");
    idle_inputs();

    // randomized traffic
    for (int c = 0; c < 1500; c++) begin
      rob_head = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) != 0)
          set_unit(i, $urandom_range(0, 4) == 0, 1'($urandom), 4'($urandom_range(0, 15)),
                   $urandom, $urandom);
      flush = ($urandom_range(0, 11) == 0);
      rst   = ($urandom_range(0, 399) == 0);
      step();
    end
    for (int c = 0; c < 8; c++) step();
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_resolver.md
# branch_resolver

Collects branch-resolution results from the N_BRU branch units in the execute stage and emits at most one resolved branch per cycle to the pipeline flush controller. A mispredict outcome is always emitted ahead of predictor training. When several mispredicts arrive in one cycle, the oldest in ROB order wins. Correctly predicted branches are queued in a small training FIFO and drained one per idle cycle. Any flush from the controller clears all in-flight state.

## Interface
- N_BRU, 2, number of branch units feeding the block
- ROB_ADDR_WIDTH, 4, width of ROB index (ROB depth = 2^ROB_ADDR_WIDTH)
- TRAIN_DEPTH, 4, training FIFO entries (power of two, ≥ N_BRU)
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush from the flush controller (mispredict or exception)
- rob_head  in  ROB_ADDR_WIDTH  index of the oldest ROB entry, used for age compare
- bru_valid  in  N_BRU  per-unit result valid
- bru_mispredict  in  N_BRU  per-unit mispredict flag
- bru_taken  in  N_BRU  per-unit actual direction
- bru_rob_id  in  N_BRU*ROB_ADDR_WIDTH  per-unit ROB index; unit i occupies bits [i*W +: W]
- bru_pc  in  N_BRU*32  per-unit branch PC
- bru_target  in  N_BRU*32  per-unit correct next PC
- resolved_valid  out  1  registered result valid, high for exactly one cycle per result
- resolved_mispredict  out  1  result is a mispredict (redirect required)
- resolved_taken  out  1  actual direction
- resolved_rob_id  out  ROB_ADDR_WIDTH  ROB index of the branch
- resolved_pc  out  32  branch PC
- resolved_target  out  32  correct next PC
- train_cnt  out  $clog2(TRAIN_DEPTH+1)  current training-FIFO occupancy
- train_drop_cnt  out  16  saturating count of training entries dropped on overflow

## Operation
- Age: age(id) = (id − rob_head) mod 2^ROB_ADDR_WIDTH. Smaller age is older. age 0 is the oldest.
- Age ties (equal rob_id, illegal but tolerated): the lower unit index wins.
- Per cycle, with flush = 0:
  - M = the set of units with bru_valid & bru_mispredict.
  - C = the set of units with bru_valid & ~bru_mispredict.
- Output register load, in priority order:
  1. If M is non-empty: load the oldest unit in M, with mispredict = 1. Units in C are still pushed.
  2. Else if the FIFO is non-empty: load the FIFO head, with mispredict = 0, and pop it.
  3. Else: resolved_valid ← 0.
- FIFO push:
  - Units in C are pushed in ascending unit index, into free slots only.
  - Entries that find no free slot are dropped. Each drop increments train_drop_cnt by 1, saturating at 0xFFFF.
  - A pop and pushes in the same cycle are both honoured. The popped slot is not reusable until the next cycle.
  - Free slots in a cycle = TRAIN_DEPTH − train_cnt (pre-pop value).
- The FIFO uses wrap-around read/write pointers of $clog2(TRAIN_DEPTH) bits plus a separate occupancy counter.
- Losing mispredicts in M (younger ones) are discarded. They are on the wrong path.
- When flush = 1 in a cycle:
  - All bru_* inputs that cycle are ignored.
  - The FIFO is emptied (pointers and count ← 0).
  - resolved_valid ← 0 at the next edge.
  - train_drop_cnt is unchanged.
- flush has priority over every other event, including a simultaneous FIFO pop or push.
- No backpressure: branch units never stall on this block.

## Timing
- Reset (rst = 1 at an edge) sets:
  - resolved_valid, resolved_mispredict, resolved_taken ← 0
  - resolved_rob_id ← 0, resolved_pc ← 0, resolved_target ← 0
  - FIFO empty, train_cnt ← 0, train_drop_cnt ← 0
- Reset mid-operation discards all queued entries.
- Mispredict latency: input at cycle t produces resolved_valid = 1, resolved_mispredict = 1 at t+1.
- Training latency: an entry pushed at cycle t is visible at the FIFO head at t+1, so the earliest output is t+2.
- The flush controller raises flush combinationally in cycle t+1, while the mispredict is on the output. Consequently:
  - Inputs present in that cycle are dropped.
  - resolved_valid = 0 at t+2.
- Any output register load happens only when not flushed. With flush = 1 at t, resolved_valid = 0 at t+1 regardless of inputs.

## Test plan
- Single mispredict:
  - Stimulus: rob_head = 0; unit0 valid, mispredict, rob_id = 3, target = 0x8000_0100 at t.
  - Response: resolved_valid = 1, mispredict = 1, rob_id = 3, target = 0x8000_0100 at t+1 only.
- Age compare with wrap:
  - Stimulus: rob_head = 14; unit0 mispredict rob_id = 1; unit1 mispredict rob_id = 15.
  - Response: output rob_id = 15 (age 1 beats age 3).
- Training drain and overflow (TRAIN_DEPTH = 4):
  - Stimulus: drive 2 correct branches per cycle for 3 cycles, no flush.
  - Response: outputs appear from t+2 in unit-index order with mispredict = 0; train_drop_cnt reaches 1; train_cnt never exceeds 4.
- Mispredict preempts training:
  - Stimulus: FIFO holds 2 entries; a mispredict arrives.
  - Response: the next output is the mispredict; the FIFO head is not popped that cycle; train_cnt = 2.
- Flush clears state:
  - Stimulus: FIFO holds 3 entries; assert flush with a simultaneous unit0 mispredict.
  - Response: resolved_valid = 0 next cycle, train_cnt = 0, mispredict not emitted.
- Reset mid-stream:
  - Stimulus: assert rst with the FIFO full and resolved_valid = 1.
  - Response: next cycle all outputs 0, train_drop_cnt = 0.
